tinker_mem_responder: RTL and testbench

TINKER_MEM_RESPONDER -- requirements
Module: tinker_mem_responder

---
 rtl/tinker_mem_pkg.sv | 33 +++
 rtl/tinker_mem_responder_if.sv | 26 ++
 rtl/tinker_mem_array.sv | 36 +++
 rtl/tinker_mem_responder.sv | 143 ++++++++++++++
 tb/tb_tinker_mem_responder.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tinker_mem_pkg.sv
// Shared types and constants for the tinker memory responder.
// The optional alignment check is enabled with the TINKER_MEM_ALIGN_CHECK_EN macro.
package tinker_mem_pkg;

    localparam int unsigned DEF_MEM_BYTES   = 524288;
    localparam int unsigned DEF_WAIT_CYCLES = 2;
    localparam int unsigned FETCH_BYTES     = 4;
    localparam int unsigned DATA_BYTES      = 8;
    localparam int unsigned ADDR_W          = 64;
    localparam int unsigned DATA_W          = 64;
    localparam int unsigned CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Request payload captured at acceptance
    typedef struct packed {
        logic              write;
        logic              fetch;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    // One-past-last byte of an access, widened so a 64-bit wrap cannot hide an overflow
    function automatic logic [ADDR_W:0] access_end(input logic [ADDR_W-1:0] addr,
                                                   input logic              fetch);
        return {1'b0, addr} + (ADDR_W+1)'(fetch ? FETCH_BYTES : DATA_BYTES);
    endfunction

endpackage

// File: rtl/tinker_mem_responder_if.sv
// Request/response bus between an initiator (master) and the memory responder (slave).
interface tinker_mem_responder_if;
    import tinker_mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_fetch;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_fetch, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_fetch, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/tinker_mem_array.sv
// Byte-addressed storage: 8-byte combinational read port, 8-byte write port with byte enables.
// Contents are never reset. Addresses wrap within the array; callers range-check first.
module tinker_mem_array
    import tinker_mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = DEF_MEM_BYTES
) (
    input  logic                         clk,
    input  logic [$clog2(MEM_BYTES)-1:0] addr,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [DATA_BYTES-1:0]        wbe,
    output logic [DATA_W-1:0]            rdata
);

    localparam int unsigned AW = $clog2(MEM_BYTES);

    logic [7:0] mem [MEM_BYTES];

    // Little-endian read of eight consecutive bytes
    always_comb begin
        rdata = '0;
        for (int k = 0; k < int'(DATA_BYTES); k++) begin
            rdata[8*k +: 8] = mem[addr + AW'(k)];
        end
    end

    // Byte-enabled little-endian write
    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(DATA_BYTES); k++) begin
            if (wbe[k]) begin
                mem[addr + AW'(k)] <= wdata[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/tinker_mem_responder.sv
// Wait-state memory responder: accepts one request, waits WAIT_CYCLES, performs the
// access and holds the response until the initiator takes it.
// Optional macro TINKER_MEM_ALIGN_CHECK_EN rejects misaligned fetch/data accesses.
module tinker_mem_responder
    import tinker_mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES   = DEF_MEM_BYTES,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    tinker_mem_responder_if.slave bus
);

    localparam int unsigned AW = $clog2(MEM_BYTES);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    req_t              cap, cap_next;
    logic              ready_q, ready_next;
    logic              valid_q, valid_next;
    logic [DATA_W-1:0] rdata_q, rdata_next;
    logic              err_q, err_next;

    logic              wr_c;
    logic              oob_c;
    logic              bad_op_c;
    logic              misalign_c;
    logic              acc_err_c;
    logic [DATA_W-1:0] load_data_c;
    logic [AW-1:0]     mem_addr_c;
    logic [DATA_BYTES-1:0] mem_wbe_c;
    logic [DATA_W-1:0] mem_rdata_c;

    // Access legality for the captured request
    assign oob_c    = access_end(cap.addr, cap.fetch) > (ADDR_W+1)'(MEM_BYTES);
    assign bad_op_c = cap.write & cap.fetch;

`ifdef TINKER_MEM_ALIGN_CHECK_EN
    assign misalign_c = cap.fetch ? (cap.addr[1:0] != 2'b00) : (cap.addr[2:0] != 3'b000);
`else
    assign misalign_c = 1'b0;
`endif

    assign acc_err_c = oob_c | bad_op_c | misalign_c;

    // Response data: zero for errors and stores, upper word cleared for fetches
    always_comb begin
        load_data_c = '0;
        if (!acc_err_c && !cap.write) begin
            load_data_c = cap.fetch ? {32'b0, mem_rdata_c[31:0]} : mem_rdata_c;
        end
    end

    // Stores are all-or-nothing; reset on the commit edge suppresses the write
    assign mem_addr_c = cap.addr[AW-1:0];
    assign mem_wbe_c  = (wr_c && !reset) ? {DATA_BYTES{1'b1}} : '0;

    tinker_mem_array #(
        .MEM_BYTES (MEM_BYTES)
    ) u_array (
        .clk   (clk),
        .addr  (mem_addr_c),
        .wdata (cap.wdata),
        .wbe   (mem_wbe_c),
        .rdata (mem_rdata_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        cap_next    = cap;
        valid_next  = valid_q;
        rdata_next  = rdata_q;
        err_next    = err_q;
        wr_c        = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    cap_next.write = bus.req_write;
                    cap_next.fetch = bus.req_fetch;
                    cap_next.addr  = bus.req_addr;
                    cap_next.wdata = bus.req_wdata;
                    cnt_next       = CNT_W'(WAIT_CYCLES);
                    state_next     = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_next = RESP;
                    valid_next = 1'b1;
                    err_next   = acc_err_c;
                    rdata_next = load_data_c;
                    wr_c       = cap.write & ~acc_err_c;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                    valid_next = 1'b0;
                    rdata_next = '0;
                    err_next   = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        ready_next = (state_next == IDLE);
    end

    // State, counter, capture and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            cap     <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            cap     <= cap_next;
            ready_q <= ready_next;
            valid_q <= valid_next;
            rdata_q <= rdata_next;
            err_q   <= err_next;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_tinker_mem_responder.sv
// Scoreboard bench for tinker_mem_responder with a byte-array reference model.
module tb_tinker_mem_responder;

    localparam int unsigned MEM_BYTES   = 524288;
    localparam int unsigned WAIT_CYCLES = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tinker_mem_responder_if bus();

    tinker_mem_responder #(
        .MEM_BYTES   (MEM_BYTES),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int unsigned acc;
    } exp_t;

    exp_t        exp_q[$];
    bit [7:0]    mdl [MEM_BYTES];
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int          rdy_mode = 1;

    // Cycle counter and global watchdog
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc > 60000) begin
            $display("FAIL watchdog: cycle %0d exceeded budget 60000", cyc);
            $fatal(1, "watchdog");
        end
    end

    // Response back-pressure generator
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.rsp_ready = 1'b0;
            1:       bus.rsp_ready = 1'b1;
            default: bus.rsp_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour: range/opcode/alignment rules, then byte-wise memory effect
    function automatic exp_t model(input bit w, input bit f, input logic [63:0] a,
                                   input logic [63:0] wd);
        exp_t        e;
        int unsigned size;
        logic [64:0] last;
        size    = f ? 4 : 8;
        last    = {1'b0, a} + 65'(size);
        e.rdata = '0;
        e.acc   = 0;
        e.err   = (w && f) || (last > 65'(MEM_BYTES));
`ifdef TINKER_MEM_ALIGN_CHECK_EN
        if ((a % 64'(size)) != 64'd0) e.err = 1'b1;
`endif
        if (!e.err) begin
            for (int k = 0; k < 8; k++) begin
                if (w) mdl[32'(a) + 32'(k)] = wd[8*k +: 8];
                else if (k < int'(size)) e.rdata[8*k +: 8] = mdl[32'(a) + 32'(k)];
            end
        end
        return e;
    endfunction

    // Present one request until accepted; keep=0 means the response is expected to be lost
    task automatic send(input bit w, input bit f, input logic [63:0] a,
                        input logic [63:0] wd, input bit keep);
        int          n = 0;
        bit          done = 0;
        int unsigned acc = 0;
        exp_t        e;
        @(negedge clk);
        bus.req_write = w;
        bus.req_fetch = f;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        while (!done) begin
            if (bus.req_ready) begin
                acc = cyc + 1;
                @(posedge clk);
                done = 1;
            end else begin
                n++;
                if (n > 2000) begin
                    errors++;
                    checks++;
                    $display("FAIL accept_timeout: got no req_ready expected acceptance addr %h", a);
                    break;
                end
                @(negedge clk);
            end
        end
        if (done && keep) begin
            e     = model(w, f, a, wd);
            e.acc = acc;
            exp_q.push_back(e);
        end
        #1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom);
        bus.req_fetch = 1'($urandom);
        bus.req_addr  = {$urandom, $urandom};
        bus.req_wdata = {$urandom, $urandom};
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || !bus.req_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            errors++;
            checks++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    // Monitor: latency, stability under back-pressure, and scoreboard compare
    logic        prev_valid = 1'b0;
    logic        held = 1'b0;
    logic [63:0] held_rd;
    logic        held_err;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_valid = 1'b0;
            held       = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", 64'(bus.rsp_valid), 64'd1);
                chk("hold_rdata", bus.rsp_rdata, held_rd);
                chk("hold_err", 64'(bus.rsp_err), 64'(held_err));
            end
            if (bus.rsp_valid) begin
                chk("busy_req_ready", 64'(bus.req_ready), 64'd0);
                if (!prev_valid) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL unexpected_rsp: got rsp_valid expected none");
                    end else begin
                        chk("latency", 64'(cyc - exp_q[0].acc), 64'(WAIT_CYCLES + 1));
                    end
                end
                if (bus.rsp_ready) begin
                    held = 1'b0;
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                        chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                    end
                end else begin
                    held     = 1'b1;
                    held_rd  = bus.rsp_rdata;
                    held_err = bus.rsp_err;
                end
            end else begin
                held = 1'b0;
            end
            prev_valid = bus.rsp_valid;
        end
    end

    initial begin
        logic [63:0] a;
        bit          w;
        bit          f;
        int          n;

        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_fetch = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        reset         = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 64'(bus.req_ready), 64'd1);
        chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("reset_rsp_rdata", bus.rsp_rdata, 64'd0);
        chk("reset_rsp_err", 64'(bus.rsp_err), 64'd0);
        reset = 1'b0;

        // Preload the working regions through the bus
        rdy_mode = 2;
        for (int unsigned p = 32'h2000; p < 32'h3100; p += 8)
            send(1'b1, 1'b0, 64'(p), {$urandom, $urandom}, 1'b1);
        for (int unsigned p = 32'h7FF00; p < 32'h80000; p += 8)
            send(1'b1, 1'b0, 64'(p), {$urandom, $urandom}, 1'b1);
        wait_idle();

        // Directed store/load/fetch and boundary cases
        send(1'b1, 1'b0, 64'h2000, 64'h1122334455667788, 1'b1);
        send(1'b0, 1'b0, 64'h2000, 64'h0, 1'b1);
        send(1'b0, 1'b1, 64'h2004, 64'h0, 1'b1);
        send(1'b1, 1'b0, 64'h7FFFC, 64'hDEADBEEFCAFEF00D, 1'b1);
        send(1'b0, 1'b1, 64'h7FFFC, 64'h0, 1'b1);
        send(1'b0, 1'b0, 64'h7FFF8, 64'h0, 1'b1);
        send(1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFC, 64'h0, 1'b1);
        send(1'b1, 1'b0, 64'hFFFFFFFFFFFFFFF8, 64'hA5A5A5A5A5A5A5A5, 1'b1);
        send(1'b0, 1'b0, 64'h80000, 64'h0, 1'b1);
        send(1'b1, 1'b1, 64'h2100, 64'h0102030405060708, 1'b1);
        send(1'b0, 1'b0, 64'h2100, 64'h0, 1'b1);
        send(1'b0, 1'b0, 64'h2001, 64'h0, 1'b1);
        wait_idle();

        // Back-pressure: response held, new request ignored until IDLE
        rdy_mode = 0;
        send(1'b0, 1'b0, 64'h2008, 64'h0, 1'b1);
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stall_rsp_seen", 64'(bus.rsp_valid), 64'd1);
        bus.req_write = 1'b0;
        bus.req_fetch = 1'b1;
        bus.req_addr  = 64'h2010;
        bus.req_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_req_ready", 64'(bus.req_ready), 64'd0);
            chk("stall_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        end
        rdy_mode = 1;
        send(1'b0, 1'b1, 64'h2010, 64'h0, 1'b1);
        wait_idle();

        // Reset on the commit edge of a store must discard it
        send(1'b1, 1'b0, 64'h3000, 64'hFEEDFACE0BADF00D, 1'b0);
        repeat (WAIT_CYCLES + 1) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_wait_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_wait_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_wait_rsp_rdata", bus.rsp_rdata, 64'd0);
        chk("rst_wait_rsp_err", 64'(bus.rsp_err), 64'd0);
        send(1'b0, 1'b0, 64'h3000, 64'h0, 1'b1);
        wait_idle();

        // Randomized mix with random back-pressure
        rdy_mode = 2;
        repeat (300) begin
            w = ($urandom_range(0, 2) == 0);
            f = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 9))
                0:       a = 64'h7FF00 + 64'($urandom_range(0, 255));
                1:       a = {32'h80000000 | $urandom, $urandom};
                default: a = 64'h2000 + 64'($urandom_range(0, 32'h10F8));
            endcase
            send(w, f, a, {$urandom, $urandom}, 1'b1);
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
